// File: rtl/multiplier.sv
// Registered signed fixed-point multiplier: full-precision product, arithmetic
// right shift by a runtime fraction-bit count, saturation into the output width.
module multiplier #(
    parameter int DATA_WIDTH_FAC1 = 8,
    parameter int DATA_WIDTH_FAC2 = 8,
    parameter int DATA_WIDTH_PROD = 20,
    parameter int Q_BITWIDTH      = $clog2(DATA_WIDTH_PROD)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              multiplier_en_i,
    input  logic signed [DATA_WIDTH_FAC1-1:0] factor_1,
    input  logic signed [DATA_WIDTH_FAC2-1:0] factor_2,
    input  logic        [Q_BITWIDTH-1:0]      fraction_bit_i,
    output logic signed [DATA_WIDTH_PROD-1:0] product
);

    localparam int FULL_W = DATA_WIDTH_FAC1 + DATA_WIDTH_FAC2;

    logic signed [FULL_W-1:0]          w_full;
    logic signed [FULL_W-1:0]          w_shift;
    logic signed [DATA_WIDTH_PROD-1:0] w_fit;
    logic signed [DATA_WIDTH_PROD-1:0] r_product;

    // Both operands are sign-extended to the full width first so the product never overflows.
    assign w_full  = FULL_W'(factor_1) * FULL_W'(factor_2);
    // Shifts past the product width still sign-fill, giving 0 or -1.
    assign w_shift = w_full >>> fraction_bit_i;

    generate
        if (DATA_WIDTH_PROD >= FULL_W) begin : g_extend
            assign w_fit = DATA_WIDTH_PROD'(w_shift);
        end else begin : g_saturate
            localparam int HI_W = FULL_W - DATA_WIDTH_PROD + 1;

            logic [HI_W-1:0] w_hi;
            logic            w_in_range;

            // The value fits only when every dropped bit equals the new sign bit.
            assign w_hi       = w_shift[FULL_W-1:DATA_WIDTH_PROD-1];
            assign w_in_range = (w_hi == '0) || (w_hi == '1);

            always_comb begin
                if (w_in_range) begin
                    w_fit = w_shift[DATA_WIDTH_PROD-1:0];
                end else if (w_shift[FULL_W-1]) begin
                    w_fit = {1'b1, {(DATA_WIDTH_PROD-1){1'b0}}};
                end else begin
                    w_fit = {1'b0, {(DATA_WIDTH_PROD-1){1'b1}}};
                end
            end
        end
    endgenerate

    // NOTE: the reset is in the sensitivity list, so it clears the register without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_product <= '0;
        end else if (multiplier_en_i) begin
            r_product <= w_fit;
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for multiplier: default 20-bit instance plus a
// 12-bit instance that exercises saturation.
module tb_multiplier;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic signed [7:0] fac1;
    logic signed [7:0] fac2;
    logic [4:0]        frac;
    logic [3:0]        frac_sat;
    logic signed [19:0] prod;
    logic signed [11:0] prod_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign frac_sat = frac[3:0];

    multiplier #(.DATA_WIDTH_PROD(20)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .multiplier_en_i(en),
        .factor_1       (fac1),
        .factor_2       (fac2),
        .fraction_bit_i (frac),
        .product        (prod)
    );

    multiplier #(.DATA_WIDTH_PROD(12)) dut_sat (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .multiplier_en_i(en),
        .factor_1       (fac1),
        .factor_2       (fac2),
        .fraction_bit_i (frac_sat),
        .product        (prod_sat)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive at the falling edge, then sample just after the next rising edge.
    task automatic step(input logic e, input int a, input int b, input int f);
        @(negedge clk);
        en   = e;
        fac1 = 8'(a);
        fac2 = 8'(b);
        frac = 5'(f);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int a;
        int b;
        int f;
        int exp;
    } vec_t;

    vec_t vecs[] = '{
        '{ 11,  11, 0,  121}, '{ 10,  11, 0,  110}, '{ 11,  10, 0,  110},
        '{-10, -10, 0,  100}, '{-11, -11, 0,  121}, '{-10, -11, 0,  110},
        '{ 10, -10, 0, -100}, '{ 11, -11, 0, -121}, '{-10,  11, 0, -110},
        '{-11,  10, 0, -110},
        '{100, 100, 4,  625}, '{-100, 100, 4, -625}, '{ -1,  1, 3,   -1},
        '{-128, -128, 0, 16384}, '{ -1,  1, 31,  -1}, '{  5,  5, 20,   0},
        '{127, 127, 0, 16129}, '{-128, 127, 0, -16256}, '{ -7, 3, 1,  -11}
    };

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        fac1  = '0;
        fac2  = '0;
        frac  = '0;
        #12;
        check("reset", int'(prod), 0);

        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 10, 10, 0);
        check("en0_after_reset", int'(prod), 0);

        step(1'b1, 10, 10, 0);
        check("first_load", int'(prod), 100);

        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", int'(prod), 0);
        @(posedge clk);
        #1;
        check("reset_held_en1", int'(prod), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reload_after_reset", int'(prod), 100);

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].f);
            check($sformatf("vec%0d_%0dx%0d_q%0d", i, vecs[i].a, vecs[i].b, vecs[i].f),
                  int'(prod), vecs[i].exp);
        end

        step(1'b1, 11, 11, 0);
        check("hold_load", int'(prod), 121);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, -5, 7, 0);
            check($sformatf("hold_%0d", k), int'(prod), 121);
        end

        // Inputs changing between edges must not reach the register.
        step(1'b1, 3, 4, 0);
        fac1 = 8'sd50;
        fac2 = 8'sd50;
        #2;
        check("between_edges", int'(prod), 12);

        step(1'b1, 127, 127, 0);
        check("sat_pos", int'(prod_sat), 2047);
        step(1'b1, -128, 127, 0);
        check("sat_neg", int'(prod_sat), -2048);
        step(1'b1, -128, -128, 0);
        check("sat_pos_corner", int'(prod_sat), 2047);
        step(1'b1, 127, 127, 4);
        check("sat_fits_after_shift", int'(prod_sat), 1008);
        step(1'b1, -64, 32, 0);
        check("sat_exact_min", int'(prod_sat), -2048);
        step(1'b1, 45, 45, 0);
        check("sat_in_range", int'(prod_sat), 2025);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
